// File: rtl/decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_nto2n_seq
// Function : Registered N-to-2^N one-hot decoder with valid/ready input,
//            pulse and latch modes, and an auto-scan mode compiled in only
//            when the DECODER_SCAN_EN macro is defined.
// Revision : 1.0  initial release
// ============================================================================
module decoder_nto2n_seq #(
    parameter int  N         = 3,
    parameter bit  MSB_FIRST = 1'b1,
    parameter int  SCAN_DIV  = 4,
    localparam int OUT_W     = 2**N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_sel,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_valid,
    output logic [N-1:0]     cur_code,
    output logic             scan_wrap
);

    localparam logic [1:0] c_MODE_PULSE = 2'b00;
    localparam logic [1:0] c_MODE_LATCH = 2'b01;

    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("decoder_nto2n_seq: SCAN_DIV must be >= 1");
    end

    logic [1:0]       r_mode_q;
    logic [OUT_W-1:0] r_onehot;
    logic [N-1:0]     r_code;
    logic             r_valid;

    logic             w_accept;
    logic             w_mode_chg;
    logic             w_nxt_valid;
    logic [N-1:0]     w_nxt_code;

    function automatic logic [OUT_W-1:0] f_decode(input logic [N-1:0] code);
        if (MSB_FIRST)
            return {1'b1, {(OUT_W-1){1'b0}}} >> code;
        else
            return {{(OUT_W-1){1'b0}}, 1'b1} << code;
    endfunction

    assign in_ready   = en & ~clr & ((mode == c_MODE_PULSE) | (mode == c_MODE_LATCH));
    assign w_accept   = in_valid & in_ready;
    assign w_mode_chg = (mode != r_mode_q);

`ifdef DECODER_SCAN_EN
    localparam logic [1:0]         c_MODE_SCAN = 2'b10;
    localparam int                 c_DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(SCAN_DIV - 1);

    logic [N-1:0]       r_scan_cnt;
    logic [N-1:0]       w_scan_cnt_nxt;
    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] w_div_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;
`endif

    always_comb begin
        w_nxt_valid = 1'b0;
        w_nxt_code  = '0;
`ifdef DECODER_SCAN_EN
        w_scan_cnt_nxt = r_scan_cnt;
        w_div_nxt      = r_div;
        w_wrap_nxt     = 1'b0;
        if (clr || w_mode_chg) begin
            w_scan_cnt_nxt = '0;
            w_div_nxt      = '0;
        end
`endif
        if (!clr && en) begin
            if (w_accept) begin
                w_nxt_valid = 1'b1;
                w_nxt_code  = in_sel;
            end else if (!w_mode_chg && (mode == c_MODE_LATCH)) begin
                w_nxt_valid = r_valid;
                w_nxt_code  = r_code;
            end
`ifdef DECODER_SCAN_EN
            else if (!w_mode_chg && (mode == c_MODE_SCAN)) begin
                w_nxt_valid = 1'b1;
                // A blank cycle (entry, clear, en low) shows the held position
                // before the divider starts counting again.
                if (!r_valid) begin
                    w_nxt_code = r_scan_cnt;
                end else if (r_div == c_DIV_LAST) begin
                    w_div_nxt      = '0;
                    w_scan_cnt_nxt = r_scan_cnt + 1'b1;
                    w_nxt_code     = r_scan_cnt + 1'b1;
                    w_wrap_nxt     = &r_scan_cnt;
                end else begin
                    w_div_nxt  = r_div + 1'b1;
                    w_nxt_code = r_scan_cnt;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= c_MODE_PULSE;
            r_valid  <= 1'b0;
            r_code   <= '0;
            r_onehot <= '0;
        end else begin
            r_mode_q <= mode;
            r_valid  <= w_nxt_valid;
            r_code   <= w_nxt_code;
            r_onehot <= w_nxt_valid ? f_decode(w_nxt_code) : '0;
        end
    end

`ifdef DECODER_SCAN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_div      <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_scan_cnt <= w_scan_cnt_nxt;
            r_div      <= w_div_nxt;
            r_wrap     <= w_wrap_nxt;
        end
    end

    assign scan_wrap = r_wrap;
`else
    assign scan_wrap = 1'b0;
`endif

    assign out_onehot = r_onehot;
    assign out_valid  = r_valid;
    assign cur_code   = r_code;

endmodule
`default_nettype wire

// File: tb/tb_decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_nto2n_seq
// Function : Self-checking bench for decoder_nto2n_seq over three parameter
//            sets, with a per-cycle reference model and directed checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_decoder_nto2n_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic       in_valid;
    logic [2:0] in_sel;
    logic       chk_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // a: N=3 MSB_FIRST=1 SCAN_DIV=4; b: N=3 MSB_FIRST=0 SCAN_DIV=4; c: N=2 MSB_FIRST=0 SCAN_DIV=2
    logic [7:0] oh_a, oh_b;
    logic [3:0] oh_c;
    logic [2:0] code_a, code_b;
    logic [1:0] code_c;
    logic       valid_a, valid_b, valid_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       ready_a, ready_b, ready_c;

    decoder_nto2n_seq #(.N(3), .MSB_FIRST(1'b1), .SCAN_DIV(4)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .in_valid(in_valid), .in_ready(ready_a), .in_sel(in_sel),
        .out_onehot(oh_a), .out_valid(valid_a), .cur_code(code_a), .scan_wrap(wrap_a)
    );

    decoder_nto2n_seq #(.N(3), .MSB_FIRST(1'b0), .SCAN_DIV(4)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .in_valid(in_valid), .in_ready(ready_b), .in_sel(in_sel),
        .out_onehot(oh_b), .out_valid(valid_b), .cur_code(code_b), .scan_wrap(wrap_b)
    );

    decoder_nto2n_seq #(.N(2), .MSB_FIRST(1'b0), .SCAN_DIV(2)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .in_valid(in_valid), .in_ready(ready_c), .in_sel(in_sel[1:0]),
        .out_onehot(oh_c), .out_valid(valid_c), .cur_code(code_c), .scan_wrap(wrap_c)
    );

    logic [7:0] a_oh[3];
    logic [2:0] a_code[3];
    logic       a_valid[3];
    logic       a_wrap[3];
    logic       a_ready[3];

    assign a_oh[0]    = oh_a;           assign a_oh[1]    = oh_b;      assign a_oh[2]    = {4'b0, oh_c};
    assign a_code[0]  = code_a;         assign a_code[1]  = code_b;    assign a_code[2]  = {1'b0, code_c};
    assign a_valid[0] = valid_a;        assign a_valid[1] = valid_b;   assign a_valid[2] = valid_c;
    assign a_wrap[0]  = wrap_a;         assign a_wrap[1]  = wrap_b;    assign a_wrap[2]  = wrap_c;
    assign a_ready[0] = ready_a;        assign a_ready[1] = ready_b;   assign a_ready[2] = ready_c;

    function automatic int pn(input int i);
        return (i == 2) ? 2 : 3;
    endfunction
    function automatic bit pmsb(input int i);
        return (i == 0);
    endfunction
    function automatic int pdiv(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    // Reference model: output described by (valid, code); scan described by
    // a step count p, the number of scan cycles advanced since the last restart.
    bit         m_valid[3];
    int         m_code[3];
    bit         m_wrap[3];
    int         m_p[3];
    logic [1:0] m_mq[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_valid[i] = 1'b0; m_code[i] = 0; m_wrap[i] = 1'b0; m_p[i] = 0; m_mq[i] = 2'b00;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int  outw;
                bit  chg;
                bit  acc;
                int  nc;
                outw    = 1 << pn(i);
                chg     = (mode != m_mq[i]);
                m_mq[i] = mode;
                acc     = in_valid && en && !clr && (mode[1] == 1'b0);
                m_wrap[i] = 1'b0;
                if (clr) begin
                    m_valid[i] = 1'b0; m_code[i] = 0; m_p[i] = 0;
                end else begin
                    if (chg) m_p[i] = 0;
                    if (!en) begin
                        m_valid[i] = 1'b0; m_code[i] = 0;
                    end else if (acc) begin
                        m_valid[i] = 1'b1; m_code[i] = int'(in_sel) % outw;
                    end else if (mode == 2'b01 && !chg) begin
                        // latch: hold
                    end
`ifdef DECODER_SCAN_EN
                    else if (mode == 2'b10 && !chg) begin
                        if (m_valid[i]) m_p[i] = m_p[i] + 1;
                        nc = (m_p[i] / pdiv(i)) % outw;
                        m_wrap[i]  = m_valid[i] && (m_code[i] == outw - 1) && (nc == 0);
                        m_valid[i] = 1'b1;
                        m_code[i]  = nc;
                    end
`endif
                    else begin
                        m_valid[i] = 1'b0; m_code[i] = 0;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] exp_oh(input int i);
        int outw;
        outw = 1 << pn(i);
        if (!m_valid[i]) return 32'd0;
        if (pmsb(i)) return 32'd1 << (outw - 1 - m_code[i]);
        return 32'd1 << m_code[i];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model onehot[%0d]", i), a_oh[i], exp_oh(i));
                chk($sformatf("model valid[%0d]", i), a_valid[i], m_valid[i]);
                chk($sformatf("model code[%0d]", i), a_code[i], m_valid[i] ? m_code[i] : 0);
                chk($sformatf("model wrap[%0d]", i), a_wrap[i], m_wrap[i]);
                chk($sformatf("model ready[%0d]", i), a_ready[i], en & ~clr & ~mode[1]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    int scan_tab[20] = '{0,0,1,1,2,2,3,3,0,0,1,1,2,2,3,3,0,0,1,1};

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'b00;
        in_valid = 1'b0; in_sel = 3'd0; chk_en = 1'b0;
        cyc(); cyc();
        chk("reset onehot", oh_a, 0);
        chk("reset valid", valid_a, 0);
        chk("reset code", code_a, 0);
        chk("reset wrap", wrap_a, 0);
        rst_n = 1'b1; chk_en = 1'b1;
        cyc();

        // latch: code 0 then 7, then hold
        en = 1'b1; mode = 2'b01; in_valid = 1'b1; in_sel = 3'd0;
        cyc();
        chk("latch code0 onehot", oh_a, 8'b1000_0000);
        in_sel = 3'd7;
        cyc();
        chk("latch code7 onehot", oh_a, 8'b0000_0001);
        chk("latch code7 cur_code", code_a, 7);
        in_valid = 1'b0;
        repeat (10) cyc();
        chk("latch hold onehot", oh_a, 8'b0000_0001);
        chk("latch hold valid", valid_a, 1);

        // pulse: back-to-back codes 2 and 5
        mode = 2'b00; in_valid = 1'b1; in_sel = 3'd2;
        cyc();
        chk("pulse code2", oh_b, 8'b0000_0100);
        in_sel = 3'd5;
        cyc();
        chk("pulse code5", oh_b, 8'b0010_0000);
        chk("pulse code5 valid", valid_b, 1);
        in_valid = 1'b0;
        cyc();
        chk("pulse end", oh_b, 0);
        chk("pulse end valid", valid_b, 0);

        // clr beats a simultaneous request
        mode = 2'b01; in_valid = 1'b1; in_sel = 3'd4;
        cyc();
        chk("latch code4", oh_a, 8'b0000_1000);
        clr = 1'b1; in_sel = 3'd1;
        #1;
        chk("clr ready", ready_a, 0);
        cyc();
        chk("clr onehot", oh_a, 0);
        clr = 1'b0; in_valid = 1'b0;
        cyc();
        chk("after clr onehot", oh_a, 0);

        // asynchronous reset in the middle of a latched output
        in_valid = 1'b1; in_sel = 3'd2;
        cyc();
        chk("latch code2", oh_a, 8'b0010_0000);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async rst onehot", oh_a, 0);
        chk("async rst valid", valid_a, 0);
        chk("async rst code", code_a, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // scan: entry cycle then 20 steps
        mode = 2'b10;
        cyc();
        chk("scan entry blank", oh_c, 0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("scan ready", ready_c, 0);
`ifdef DECODER_SCAN_EN
            chk($sformatf("scan code k=%0d", k), code_c, scan_tab[k]);
            chk($sformatf("scan wrap k=%0d", k), wrap_c, (k == 8 || k == 16));
`else
            chk($sformatf("scan off onehot k=%0d", k), oh_c, 0);
            chk($sformatf("scan off wrap k=%0d", k), wrap_c, 0);
`endif
        end

        // en low freezes the scan position
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (9) cyc();
`ifdef DECODER_SCAN_EN
        chk("scan at code2", code_a, 2);
        chk("scan at code2 onehot", oh_a, 8'b0010_0000);
`else
        chk("scan off at code2", oh_a, 0);
`endif
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("en low onehot", oh_a, 0);
            chk("en low wrap", wrap_a, 0);
        end
        en = 1'b1;
        cyc();
`ifdef DECODER_SCAN_EN
        chk("resume code", code_a, 2);
        chk("resume onehot", oh_a, 8'b0010_0000);
`else
        chk("resume off onehot", oh_a, 0);
        chk("resume off valid", valid_a, 0);
`endif

        // reserved mode
        mode = 2'b11; in_valid = 1'b1; in_sel = 3'd5;
        #1;
        chk("mode11 ready", ready_b, 0);
        cyc();
        chk("mode11 onehot", oh_b, 0);
        cyc();
        chk("mode11 hold zero", oh_b, 0);

        chk_en = 1'b0;
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
